// File: rtl/addrdecode_skid_pkg.sv
// Shared definitions for the address decoder with skid buffer.
//
// Contents:
//   TABLE_W            - widest NS*AW the default table generators cover
//   decode_width()     - width of the one-hot decode vector (NS slaves + "no slave")
//   default_slave_addr - default base table: slave k at k << (AW-3)
//   default_slave_mask - default mask table: top three address bits per slave
package addrdecode_skid_pkg;

    localparam int TABLE_W = 1024;

    // One bit per slave plus a trailing "no slave matched" bit.
    function automatic int decode_width(input int ns);
        return ns + 1;
    endfunction

    function automatic logic [TABLE_W-1:0] default_slave_addr(input int ns, input int aw);
        logic [TABLE_W-1:0] tbl;
        logic [TABLE_W-1:0] field;
        tbl   = '0;
        field = (TABLE_W'(1) << aw) - TABLE_W'(1);
        for (int k = 0; k < ns; k++) begin
            // Keep each base inside its own AW-wide slot.
            tbl = tbl | (((TABLE_W'(k) << (aw - 3)) & field) << (k * aw));
        end
        return tbl;
    endfunction

    function automatic logic [TABLE_W-1:0] default_slave_mask(input int ns, input int aw);
        logic [TABLE_W-1:0] tbl;
        tbl = '0;
        for (int k = 0; k < ns; k++) begin
            tbl = tbl | ((TABLE_W'(7) << (aw - 3)) << (k * aw));
        end
        return tbl;
    endfunction

endpackage

// File: rtl/addrdecode_skid_skidbuffer.sv
// One-entry holding register used when the output stage is stalled.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   load      - capture entry_in (only ever asserted while empty)
//   unload    - release the held entry to the output stage
//   entry_in  - packed {decode, addr, data} to hold
//   full      - entry occupied
//   entry     - held entry (zero while empty when OPT_LOWPOWER is set)
module skidbuffer #(
    parameter int W            = 8,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] entry_in,
    output logic         full,
    output logic [W-1:0] entry
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= entry_in;
        end else if (unload) begin
            full <= 1'b0;
            if (OPT_LOWPOWER) begin
                entry <= '0;
            end
        end
    end

endmodule

// File: rtl/addrdecode_skid.sv
// Address decoder with a registered output stage and a one-entry skid buffer.
// Each accepted request is decoded to a one-hot slave select (bit NS means no
// slave matched) and presented downstream one cycle later together with its
// address and payload.
//
// Handshake: upstream transfers when i_valid && !o_stall; downstream transfers
// when o_valid && !i_stall. o_stall is the skid-occupied flag, so it is a
// registered signal and the skid can always absorb the one request accepted
// in the cycle the output stage becomes blocked.
//
// Ports:
//   i_clk, i_reset   - clock, asynchronous active-high reset
//   i_valid, o_stall - upstream request / stall
//   i_addr, i_data   - request address / payload
//   o_valid, i_stall - downstream valid / stall
//   o_decode         - one-hot slave select, NS+1 bits
//   o_addr, o_data   - registered address / payload
//   i_clear          - synchronous clear of the miss counter
//   o_miss_count     - saturating count of no-slave transfers leaving the output
module addrdecode_skid
    import addrdecode_skid_pkg::*;
#(
    parameter int              NS             = 8,
    parameter int              AW             = 32,
    parameter int              DW             = 32,
    parameter logic [NS*AW-1:0] SLAVE_ADDR    = (NS*AW)'(default_slave_addr(NS, AW)),
    parameter logic [NS*AW-1:0] SLAVE_MASK    = (NS*AW)'(default_slave_mask(NS, AW)),
    parameter logic [NS-1:0]   ACCESS_ALLOWED = {NS{1'b1}},
    parameter bit              OPT_LOWPOWER   = 1'b0,
    parameter int              CW             = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_stall,
    input  logic [AW-1:0]               i_addr,
    input  logic [DW-1:0]               i_data,
    output logic                        o_valid,
    input  logic                        i_stall,
    output logic [decode_width(NS)-1:0] o_decode,
    output logic [AW-1:0]               o_addr,
    output logic [DW-1:0]               o_data,
    input  logic                        i_clear,
    output logic [CW-1:0]               o_miss_count
);

    localparam int DECW = decode_width(NS);
    localparam int EW   = DECW + AW + DW;

    logic [NS-1:0]   slave_hit;
    logic [DECW-1:0] in_decode;
    logic            found;
    logic            accept;
    logic            out_ready;
    logic            skid_full;
    logic            skid_load;
    logic            skid_unload;
    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   skid_entry;
    logic [CW-1:0]   miss_count;

    // Per-slave address match, gated by the access table.
    always_comb begin
        slave_hit = '0;
        for (int k = 0; k < NS; k++) begin
            slave_hit[k] = (((i_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0)
                           && ACCESS_ALLOWED[k];
        end
    end

    // Lowest matching index wins; no match selects the trailing bit.
    always_comb begin
        in_decode = '0;
        found     = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (!found && slave_hit[k]) begin
                in_decode[k] = 1'b1;
                found        = 1'b1;
            end
        end
        in_decode[NS] = !found;
    end

    assign accept      = i_valid && !o_stall;
    assign out_ready   = !o_valid || !i_stall;
    assign in_entry    = {in_decode, i_addr, i_data};
    // New request goes to the skid only when the output stage cannot take it.
    assign skid_load   = accept && !out_ready;
    assign skid_unload = skid_full && out_ready;

    skidbuffer #(
        .W            (EW),
        .OPT_LOWPOWER (OPT_LOWPOWER)
    ) u_skid (
        .clk      (i_clk),
        .rst      (i_reset),
        .load     (skid_load),
        .unload   (skid_unload),
        .entry_in (in_entry),
        .full     (skid_full),
        .entry    (skid_entry)
    );

    assign o_stall = skid_full;

    // Output stage: the skid entry is older than anything on the input, so it
    // always loads first. While the skid is full no input is accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_decode <= '0;
            o_addr   <= '0;
            o_data   <= '0;
        end else if (out_ready) begin
            if (skid_full) begin
                {o_decode, o_addr, o_data} <= skid_entry;
            end else if (accept) begin
                {o_decode, o_addr, o_data} <= in_entry;
            end else begin
                o_decode <= '0;
                if (OPT_LOWPOWER) begin
                    o_addr <= '0;
                    o_data <= '0;
                end
            end
        end
    end

    // A loaded decode is always one-hot, an empty stage is all zero.
    assign o_valid = |o_decode;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            miss_count <= '0;
        end else if (i_clear) begin
            miss_count <= '0;
        end else if (o_valid && !i_stall && o_decode[NS] && !(&miss_count)) begin
            miss_count <= miss_count + CW'(1);
        end
    end

    assign o_miss_count = miss_count;

endmodule

// File: tb/tb_addrdecode_skid.sv
// Directed bench for addrdecode_skid: NS=4, AW=8, DW=8, CW=4.
// Slave table: 00/C0, 40/C0, 80/C0, 80/80, slave 3 not accessible.
// A second instance with OPT_LOWPOWER=1 shares all inputs.
module tb_addrdecode_skid;

    localparam int NS = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam logic [NS*AW-1:0] T_ADDR  = 32'h8080_4000;
    localparam logic [NS*AW-1:0] T_MASK  = 32'h80C0_C0C0;
    localparam logic [NS-1:0]    T_ALLOW = 4'b0111;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          stall;
    logic          clear;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    logic          o_stall, o_valid;
    logic [NS:0]   o_decode;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_miss;

    logic          lp_stall, lp_valid;
    logic [NS:0]   lp_decode;
    logic [AW-1:0] lp_addr;
    logic [DW-1:0] lp_data;
    logic [CW-1:0] lp_miss;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int snap;
    logic [AW+DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    addrdecode_skid #(
        .NS(NS), .AW(AW), .DW(DW), .SLAVE_ADDR(T_ADDR), .SLAVE_MASK(T_MASK),
        .ACCESS_ALLOWED(T_ALLOW), .OPT_LOWPOWER(1'b0), .CW(CW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_stall(o_stall),
        .i_addr(addr), .i_data(data), .o_valid(o_valid), .i_stall(stall),
        .o_decode(o_decode), .o_addr(o_addr), .o_data(o_data),
        .i_clear(clear), .o_miss_count(o_miss)
    );

    addrdecode_skid #(
        .NS(NS), .AW(AW), .DW(DW), .SLAVE_ADDR(T_ADDR), .SLAVE_MASK(T_MASK),
        .ACCESS_ALLOWED(T_ALLOW), .OPT_LOWPOWER(1'b1), .CW(CW)
    ) dut_lp (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_stall(lp_stall),
        .i_addr(addr), .i_data(data), .o_valid(lp_valid), .i_stall(stall),
        .o_decode(lp_decode), .o_addr(lp_addr), .o_data(lp_data),
        .i_clear(clear), .o_miss_count(lp_miss)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver / scoreboard ----------------
    // Inputs are set at a negedge; this evaluates the handshakes that the
    // coming posedge will perform, then advances to the next negedge.
    task automatic tick();
        logic [AW+DW-1:0] e;
        if (!rst && o_valid && !stall) begin
            n_out++;
            check("out_onehot", 32'($onehot(o_decode)), 32'd1);
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_order", 32'({o_addr, o_data}), 32'(e));
            end
        end
        if (!rst && valid && !o_stall) exp_q.push_back({addr, data});
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0; clear = 1'b0; addr = '0; data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid",  32'(o_valid),  32'h0);
        check("rst_stall",  32'(o_stall),  32'h0);
        check("rst_decode", 32'(o_decode), 32'h0);
        check("rst_miss",   32'(o_miss),   32'h0);
        check("rst_addr",   32'(o_addr),   32'h0);
        check("rst_data",   32'(o_data),   32'h0);

        // First acceptance on the first edge after reset release, back to back.
        rst = 1'b0; valid = 1'b1; addr = 8'h45; data = 8'h11;
        tick();
        check("dec_45",   32'(o_decode), 32'h02);
        check("valid_45", 32'(o_valid),  32'h1);
        check("addr_45",  32'(o_addr),   32'h45);
        check("data_45",  32'(o_data),   32'h11);
        addr = 8'h85; data = 8'h22;
        tick();
        check("dec_85",  32'(o_decode), 32'h04);
        check("addr_85", 32'(o_addr),   32'h85);
        addr = 8'hC5; data = 8'h33;
        tick();
        check("dec_C5",      32'(o_decode), 32'h10);
        check("miss_before", 32'(o_miss),   32'h0);
        valid = 1'b0;
        tick();
        check("miss_1",       32'(o_miss),    32'h1);
        check("idle_valid",   32'(o_valid),   32'h0);
        check("idle_decode",  32'(o_decode),  32'h0);
        check("lp_idle_addr", 32'(lp_addr),   32'h0);
        check("lp_idle_data", 32'(lp_data),   32'h0);
        check("lp_idle_dec",  32'(lp_decode), 32'h0);

        // Downstream stall for three edges with back-to-back requests.
        snap = n_out;
        stall = 1'b1; valid = 1'b1; addr = 8'h01; data = 8'h44;
        tick();
        check("st1_valid", 32'(o_valid), 32'h1);
        check("st1_addr",  32'(o_addr),  32'h01);
        check("st1_stall", 32'(o_stall), 32'h0);
        addr = 8'h41; data = 8'h55;
        tick();
        check("st2_stall", 32'(o_stall), 32'h1);
        check("st2_hold",  32'(o_addr),  32'h01);
        addr = 8'h81; data = 8'h66;
        tick();
        check("st3_stall",  32'(o_stall),  32'h1);
        check("st3_hold",   32'(o_addr),   32'h01);
        check("st3_decode", 32'(o_decode), 32'h01);
        stall = 1'b0;
        tick();
        check("skid_out_addr", 32'(o_addr),  32'h41);
        check("skid_out_data", 32'(o_data),  32'h55);
        check("stall_drop",    32'(o_stall), 32'h0);
        tick();
        check("third_addr", 32'(o_addr),   32'h81);
        check("third_dec",  32'(o_decode), 32'h04);
        valid = 1'b0;
        tick();
        check("drain_valid", 32'(o_valid),        32'h0);
        check("drain_count", 32'(n_out - snap),   32'd3);
        check("drain_queue", 32'(exp_q.size()),   32'd0);

        // Miss counter saturation and clear priority.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("miss_clear", 32'(o_miss), 32'h0);
        valid = 1'b1;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            addr = 8'hC0 + 8'(i); data = 8'(i);
            tick();
        end
        valid = 1'b0;
        tick();
        check("miss_sat",    32'(o_miss),  32'hF);
        check("lp_miss_sat", 32'(lp_miss), 32'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("miss_clr2", 32'(o_miss), 32'h0);
        valid = 1'b1; addr = 8'hC7; data = 8'hAA;
        tick();
        valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_wins", 32'(o_miss), 32'h0);
        tick();
        check("clear_stays", 32'(o_miss), 32'h0);

        // Reset while output is held and skid is full.
        stall = 1'b1; valid = 1'b1; addr = 8'h02; data = 8'h77;
        tick();
        addr = 8'h42; data = 8'h88;
        tick();
        check("pre_rst_valid", 32'(o_valid), 32'h1);
        check("pre_rst_stall", 32'(o_stall), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_valid",  32'(o_valid),  32'h0);
        check("async_stall",  32'(o_stall),  32'h0);
        check("async_decode", 32'(o_decode), 32'h0);
        exp_q.delete();
        valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("post_rst_valid", 32'(o_valid), 32'h0);
        check("post_rst_stall", 32'(o_stall), 32'h0);
        check("post_rst_addr",  32'(o_addr),  32'h0);
        valid = 1'b1; addr = 8'h46; data = 8'h99;
        tick();
        check("restart_addr", 32'(o_addr),   32'h46);
        check("restart_dec",  32'(o_decode), 32'h02);
        valid = 1'b0;
        tick();
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("lp_end_addr", 32'(lp_addr),      32'h0);
        check("lp_end_data", 32'(lp_data),      32'h0);
        check("lp_end_dec",  32'(lp_decode),    32'h0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
